// File: rtl/ecc_serial_loader.sv
// ecc_serial_loader
// Serial-to-parallel input stage for the ECC point-multiply core.
// A full load captures the 2-bit key-size mode, then shifts the six operands
// (a, b, prime, Px, Py, m) in MSB first. Once a full load has completed, any
// later load is a point reload: only Px/Py are shifted and the stored curve
// parameters, scalar and mode are reused. Each finished load raises o_start
// for one cycle, with o_reload telling the core which kind of load it was.

module ecc_serial_loader #(
    parameter int MAX_BITS = 128,
    parameter int CNT_W    = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_data_valid,
    input  logic                i_mode,
    input  logic                i_a,
    input  logic                i_b,
    input  logic                i_prime,
    input  logic                i_Px,
    input  logic                i_Py,
    input  logic                i_m,
    input  logic                i_core_busy,
    output logic [1:0]          o_mode,
    output logic [MAX_BITS-1:0] o_a,
    output logic [MAX_BITS-1:0] o_b,
    output logic [MAX_BITS-1:0] o_prime,
    output logic [MAX_BITS-1:0] o_m,
    output logic [MAX_BITS-1:0] o_Px,
    output logic [MAX_BITS-1:0] o_Py,
    output logic                o_start,
    output logic                o_reload,
    output logic                o_busy
);

    typedef enum logic [2:0] {
        IDLE,
        MODE1,
        MODE0,
        SHIFT,
        DONE
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   bit_cnt;
    // Set by the first completed full load; selects reload for later loads.
    // It only changes in DONE, so it is stable for the whole of a load.
    logic               have_params;

    // A load request is accepted only in IDLE with the core free; a request at
    // any other time is dropped rather than remembered.
    logic               load_accept;
    // High on the edge that takes the last serial bit.
    logic               last_bit;

    // Operand width in bits for a key-size code: 16, 32, 64 or 128.
    function automatic logic [CNT_W-1:0] size_bits(input logic [1:0] mode);
        return CNT_W'(16) << mode;
    endfunction

    // Append one serial bit at the LSB end; N shifts into a cleared word leave
    // the operand in bits [N-1:0] with everything above still zero.
    function automatic logic [MAX_BITS-1:0] shift_in(input logic [MAX_BITS-1:0] word,
                                                     input logic                bit_in);
        return {word[MAX_BITS-2:0], bit_in};
    endfunction

    // NOTE: pure combinational decode with no else-less paths, so no latch is inferred.
    assign load_accept = (state == IDLE) && i_data_valid && !i_core_busy;
    assign last_bit    = (state == SHIFT) && (bit_cnt == CNT_W'(1));

    // Control state machine: sequencing, bit counter and the registered status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            bit_cnt     <= '0;
            have_params <= 1'b0;
            o_mode      <= 2'b00;
            o_start     <= 1'b0;
            o_reload    <= 1'b0;
            o_busy      <= 1'b0;
        end else begin
            // NOTE: state is written with non-blocking assignments so every
            // register here sees the pre-edge values of the others.
            o_start <= 1'b0;
            case (state)
                IDLE: begin
                    if (load_accept) begin
                        o_busy <= 1'b1;
                        if (have_params) begin
                            // Reload skips the mode phase and reuses the stored size.
                            bit_cnt <= size_bits(o_mode);
                            state   <= SHIFT;
                        end else begin
                            state <= MODE1;
                        end
                    end
                end

                MODE1: begin
                    o_mode[1] <= i_mode;
                    state     <= MODE0;
                end

                MODE0: begin
                    o_mode[0] <= i_mode;
                    bit_cnt   <= size_bits({o_mode[1], i_mode});
                    state     <= SHIFT;
                end

                SHIFT: begin
                    bit_cnt <= bit_cnt - CNT_W'(1);
                    if (last_bit) begin
                        // Raise o_start on the same edge as entering DONE so the
                        // pulse occupies exactly the DONE cycle.
                        o_start  <= 1'b1;
                        o_reload <= have_params;
                        state    <= DONE;
                    end
                end

                DONE: begin
                    have_params <= 1'b1;
                    o_busy      <= 1'b0;
                    state       <= IDLE;
                end

                default: begin
                    state  <= IDLE;
                    o_busy <= 1'b0;
                end
            endcase
        end
    end

    // Curve parameters and scalar: cleared at the start of a full load and
    // shifted only during a full load, so a reload leaves them untouched.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_a     <= '0;
            o_b     <= '0;
            o_prime <= '0;
            o_m     <= '0;
        end else if (state == MODE0) begin
            o_a     <= '0;
            o_b     <= '0;
            o_prime <= '0;
            o_m     <= '0;
        end else if (state == SHIFT && !have_params) begin
            o_a     <= shift_in(o_a, i_a);
            o_b     <= shift_in(o_b, i_b);
            o_prime <= shift_in(o_prime, i_prime);
            o_m     <= shift_in(o_m, i_m);
        end
    end

    // Point coordinates: cleared at the start of either kind of load and
    // shifted during every SHIFT phase.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_Px <= '0;
            o_Py <= '0;
        end else if ((state == MODE0) || (load_accept && have_params)) begin
            o_Px <= '0;
            o_Py <= '0;
        end else if (state == SHIFT) begin
            o_Px <= shift_in(o_Px, i_Px);
            o_Py <= shift_in(o_Py, i_Py);
        end
    end

endmodule

// File: tb/tb_ecc_serial_loader.sv
// tb_ecc_serial_loader
// Drives full loads and point reloads bit by bit and compares the loader's
// outputs against a simple operand/state model kept in the bench.

module tb_ecc_serial_loader;

    localparam int MB = 128;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_data_valid;
    logic          i_mode;
    logic          i_a, i_b, i_prime, i_Px, i_Py, i_m;
    logic          i_core_busy;
    logic [1:0]    o_mode;
    logic [MB-1:0] o_a, o_b, o_prime, o_m, o_Px, o_Py;
    logic          o_start, o_reload, o_busy;

    int total = 0;
    int bad   = 0;

    // Reference state: what the loader should be holding.
    logic          m_have;
    logic [1:0]    m_mode;
    logic [MB-1:0] m_a, m_b, m_p, m_m, m_px, m_py;

    ecc_serial_loader #(.MAX_BITS(MB), .CNT_W(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .i_data_valid (i_data_valid),
        .i_mode       (i_mode),
        .i_a          (i_a),
        .i_b          (i_b),
        .i_prime      (i_prime),
        .i_Px         (i_Px),
        .i_Py         (i_Py),
        .i_m          (i_m),
        .i_core_busy  (i_core_busy),
        .o_mode       (o_mode),
        .o_a          (o_a),
        .o_b          (o_b),
        .o_prime      (o_prime),
        .o_m          (o_m),
        .o_Px         (o_Px),
        .o_Py         (o_Py),
        .o_start      (o_start),
        .o_reload     (o_reload),
        .o_busy       (o_busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [MB-1:0] got, input logic [MB-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic check_words(input string tag);
        check({tag, ".mode"},  MB'(o_mode), MB'(m_mode));
        check({tag, ".a"},     o_a,     m_a);
        check({tag, ".b"},     o_b,     m_b);
        check({tag, ".prime"}, o_prime, m_p);
        check({tag, ".m"},     o_m,     m_m);
        check({tag, ".Px"},    o_Px,    m_px);
        check({tag, ".Py"},    o_Py,    m_py);
    endtask

    task automatic model_clear();
        m_have = 1'b0;
        m_mode = 2'b00;
        m_a = '0; m_b = '0; m_p = '0; m_m = '0; m_px = '0; m_py = '0;
    endtask

    task automatic float_data();
        i_mode = 1'bx;
        i_a = 1'bx; i_b = 1'bx; i_prime = 1'bx; i_m = 1'bx; i_Px = 1'bx; i_Py = 1'bx;
    endtask

    function automatic logic [MB-1:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // One load, starting and ending on a falling edge. The load kind follows the
    // model: full until a full load has completed, reload afterwards.
    // rst_bit >= 0 asserts reset while that data bit (0 = first) is presented.
    // spur_bit >= 0 pulses i_data_valid while that data bit is presented.
    task automatic do_load(input string tag, input logic [1:0] mode,
                           input logic [MB-1:0] a, input logic [MB-1:0] b,
                           input logic [MB-1:0] p, input logic [MB-1:0] px,
                           input logic [MB-1:0] py, input logic [MB-1:0] m,
                           input int rst_bit, input int spur_bit);
        logic          full;
        logic [1:0]    use_mode;
        int            n;
        logic [MB-1:0] mask;
        full     = !m_have;
        use_mode = full ? mode : m_mode;
        n        = 16 << use_mode;
        mask     = (MB'(1) << n) - MB'(1);

        i_data_valid = 1'b1;
        @(negedge clk);
        i_data_valid = 1'b0;
        check({tag, ".busy_on"}, MB'(o_busy), MB'(1));
        if (full) begin
            i_mode = mode[1];
            @(negedge clk);
            i_mode = mode[0];
            @(negedge clk);
            i_mode = 1'bx;
        end
        for (int i = n - 1; i >= 0; i--) begin
            if (n - 1 - i == rst_bit) begin
                rst = 1'b1;
                float_data();
                @(negedge clk);
                model_clear();
                check({tag, ".rst_start"},  MB'(o_start),  MB'(0));
                check({tag, ".rst_reload"}, MB'(o_reload), MB'(0));
                check({tag, ".rst_busy"},   MB'(o_busy),   MB'(0));
                check_words({tag, ".rst"});
                rst = 1'b0;
                repeat (3) begin
                    @(negedge clk);
                    check({tag, ".rst_nostart"}, MB'(o_start), MB'(0));
                end
                return;
            end
            i_data_valid = (n - 1 - i == spur_bit);
            i_a = a[i]; i_b = b[i]; i_prime = p[i];
            i_Px = px[i]; i_Py = py[i]; i_m = m[i];
            check({tag, ".no_early_start"}, MB'(o_start), MB'(0));
            @(negedge clk);
        end
        i_data_valid = 1'b0;
        float_data();

        if (full) begin
            m_mode = mode;
            m_a = a & mask; m_b = b & mask; m_p = p & mask; m_m = m & mask;
        end
        m_px = px & mask;
        m_py = py & mask;
        check({tag, ".start"},  MB'(o_start),  MB'(1));
        check({tag, ".reload"}, MB'(o_reload), MB'(!full));
        check_words({tag, ".at_start"});
        m_have = 1'b1;

        @(negedge clk);
        check({tag, ".start_1cyc"}, MB'(o_start), MB'(0));
        check({tag, ".busy_off"},   MB'(o_busy),  MB'(0));
        check_words({tag, ".hold"});
    endtask

    initial begin
        rst          = 1'b1;
        i_data_valid = 1'b0;
        i_core_busy  = 1'b0;
        float_data();
        model_clear();
        repeat (2) @(negedge clk);
        check("reset.start",  MB'(o_start),  MB'(0));
        check("reset.reload", MB'(o_reload), MB'(0));
        check("reset.busy",   MB'(o_busy),   MB'(0));
        check_words("reset");
        rst = 1'b0;
        @(negedge clk);

        // 16-bit full load with fixed operands, then a point reload.
        do_load("t1_full16", 2'b00, 128'h0003, 128'h0007, 128'hFFF1,
                128'h1234, 128'h0ABC, 128'h00FF, -1, -1);
        do_load("t2_reload", 2'b11, 128'h0, 128'h0, 128'h0,
                128'h4321, 128'h0CBA, 128'h0, -1, -1);

        // 128-bit full load, every bit set.
        rst = 1'b1; @(negedge clk); rst = 1'b0; model_clear(); @(negedge clk);
        do_load("t3_full128", 2'b11, '1, '1, '1, '1, '1, '1, -1, -1);

        // Reset during the 20th bit of a 32-bit load, then a fresh load must be full.
        do_load("t4_abort", 2'b01, rnd128(), rnd128(), rnd128(),
                rnd128(), rnd128(), rnd128(), -1, -1);
        rst = 1'b1; @(negedge clk); rst = 1'b0; model_clear(); @(negedge clk);
        do_load("t4_rst", 2'b01, rnd128(), rnd128(), rnd128(),
                rnd128(), rnd128(), rnd128(), 19, -1);
        do_load("t4_after", 2'b01, rnd128(), rnd128(), rnd128(),
                rnd128(), rnd128(), rnd128(), -1, -1);

        // Stray request during SHIFT, then a request while the core is busy.
        do_load("t5_spur", 2'b00, '0, '0, '0, rnd128(), rnd128(), '0, -1, 5);
        i_core_busy  = 1'b1;
        i_data_valid = 1'b1;
        @(negedge clk);
        i_data_valid = 1'b0;
        repeat (4) begin
            check("t5_busy.idle", MB'(o_busy),  MB'(0));
            check("t5_busy.nostart", MB'(o_start), MB'(0));
            @(negedge clk);
        end
        check_words("t5_busy");
        i_core_busy = 1'b0;

        // 64-bit bit-ordering check.
        rst = 1'b1; @(negedge clk); rst = 1'b0; model_clear(); @(negedge clk);
        do_load("t6_order", 2'b10, rnd128(), rnd128(), rnd128(),
                128'h8000_0000_0000_0001, rnd128(), rnd128(), -1, -1);
        check("t6_order.px_exact", o_Px, 128'h8000_0000_0000_0001);

        // Randomized mix of full loads (after occasional resets) and reloads.
        for (int t = 0; t < 24; t++) begin
            if ($urandom_range(0, 3) == 0) begin
                rst = 1'b1; @(negedge clk); rst = 1'b0; model_clear(); @(negedge clk);
            end
            repeat ($urandom_range(0, 3)) @(negedge clk);
            do_load("rand", 2'($urandom_range(0, 3)), rnd128(), rnd128(), rnd128(),
                    rnd128(), rnd128(), rnd128(), -1,
                    ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 15)) : -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
